copier_dm_scheduler: RTL
========================

Name: copier_dm_scheduler

Overview:
- Sequences and shares the copier's 64W x 32 single-port data memory between two requesters.
- Requester 1: the CPU local-I/O path (AQ/WQ/RQ queue protocol).
- Requester 2: a block-copy engine that streams bursts of up to 64 words in or out.
- Owns the RAM's address/data/write-enable pins. The RAM is combinational-read (data valid in the same cycle as its address).

Parameters:
- ADDR_W, 6, RAM address width (depth 2^ADDR_W).
- DATA_W, 32, RAM word width.
- MAX_BURST, 8, max consecutive engine words while cpu_sel is pending before the CPU is given one slot.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_sel  in  1  CPU request; AQ/WQ outputs are valid and held until cpu_done.
- cpu_aq  in  ADDR_W  CPU word address.
- cpu_read  in  1  1 = read, 0 = write.
- cpu_wq  in  DATA_W  CPU write data.
- cpu_rq  out  DATA_W  read data to the read queue.
- cpu_wrq  out  1  write the read queue.
- cpu_rwq  out  1  read (pop) the write queue.
- cpu_done  out  1  CPU access complete; pop AQ.
- eng_req  in  1  start a burst; sampled in IDLE only.
- eng_addr  in  ADDR_W  burst start address.
- eng_len  in  7  burst length in words.
- eng_write  in  1  1 = burst writes RAM, 0 = burst reads RAM.
- eng_wdata  in  DATA_W  engine write data.
- eng_wvalid  in  1  eng_wdata valid.
- eng_wnext  out  1  current eng_wdata consumed this cycle.
- eng_rdata  out  DATA_W  registered engine read data.
- eng_rvalid  out  1  eng_rdata valid.
- eng_busy  out  1  burst accepted and not finished.
- eng_done  out  1  one-cycle pulse after the last word.
- ram_a  out  ADDR_W  RAM address.
- ram_d  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_q  in  DATA_W  RAM combinational read data.

Behaviour:
- Reset state: async reset_n low forces IDLE and drives every output to 0, including ram_we.
  - Reset mid-burst abandons the burst: no eng_done, no further RAM writes.
  - Pending CPU request is re-served after release.
- States: IDLE, CPU_ACC, ENG_RUN, ENG_FIN.
- IDLE:
  - cpu_sel=1 -> CPU_ACC. CPU has priority when eng_req is also set.
  - else eng_req=1 -> latch base=eng_addr, cnt=0, dir=eng_write.
  - len=0 -> ENG_FIN with no RAM access.
  - len>64 -> clamp to 64, then ENG_RUN.
- CPU_ACC (always one cycle):
  - ram_a=cpu_aq; cpu_done=1; cpu_rq=ram_q.
  - cpu_wrq=cpu_read; cpu_rwq=~cpu_read.
  - ram_we=~cpu_read; ram_d=cpu_wq.
  - Next state: ENG_RUN if eng_busy, else IDLE.
  - An internal guard stops cpu_sel from re-granting in the cycle after cpu_done, so AQ can advance.
  - CPU latency: cpu_sel first seen at cycle N -> cpu_done at N+1 when uncontended.
- ENG_RUN:
  - ram_a=(base+cnt) mod 2^ADDR_W; wrap-around is required.
  - Write burst: word completes only when eng_wvalid=1; then ram_we=1, ram_d=eng_wdata, eng_wnext=1, cnt++.
  - Read burst: word completes every cycle; eng_rdata<=ram_q and eng_rvalid<=1 on the next cycle; cnt++.
  - A run counter counts consecutive completed words while cpu_sel=1.
  - -> CPU_ACC when the run counter reaches MAX_BURST, or when a write burst stalls (eng_wvalid=0) with cpu_sel=1. The counter clears on entering CPU_ACC.
  - -> ENG_FIN when the last word (cnt=len-1) completes. The last word completes before the CPU is served, even if preemption is also due.
- ENG_FIN: eng_done=1 for one cycle, eng_busy drops; -> IDLE.
- eng_busy=1 from the cycle after acceptance through ENG_FIN inclusive.
- RAM drive rules:
  - ram_we is never asserted outside a granted slot.
  - Exactly one requester drives ram_a in any cycle.
  - IDLE drives ram_a=0, ram_we=0.

Optional Feature:
- Macro: COPIER_DM_PERF_EN.
- Defined: adds outputs perf_cpu_wait[15:0] and perf_eng_words[15:0].
  - perf_cpu_wait counts cycles with cpu_sel=1 and no cpu_done.
  - perf_eng_words counts completed engine words.
  - Both are saturating and cleared by reset_n.
- Undefined: the ports do not exist and no counter logic is built.

Test Plan:
- CPU write 0xDEADBEEF to addr 5, then CPU read addr 5 -> cpu_done one cycle after each cpu_sel; cpu_rwq on the write; cpu_wrq with cpu_rq=0xDEADBEEF on the read; latency 1 cycle each.
- Engine write burst addr=60, len=8, data 1..8 with eng_wvalid always 1 -> RAM 60..63 = 1..4 and RAM 0..3 = 5..8 (wrap); eng_done 9 cycles after eng_req; then a read burst returns 1..8 on eng_rvalid.
- CPU held continuously during a 64-word read burst, MAX_BURST=8 -> CPU_ACC inserted after every 8 engine words; eng_done after 64 words plus the CPU slots; no word lost or duplicated.
- Write burst with eng_wvalid low for 3 cycles and cpu_sel asserted -> CPU served in the stall; no ram_we for the engine while eng_wvalid=0.
- eng_len=0, then eng_len=100 -> first gives eng_done with no ram_we; second clamps to exactly 64 words.
- reset_n pulsed low at the 4th word of a write burst -> all outputs 0 immediately; no eng_done; words 5+ unwritten; a new burst after release works.

Source files
------------

// File: rtl/copier_dm_scheduler.sv
// Shares the copier's single-port data RAM between the CPU local-I/O queues and a
// block-copy engine. Define COPIER_DM_PERF_EN to add saturating performance counters.
module copier_dm_scheduler #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_sel,
  input  logic [ADDR_W-1:0] cpu_aq,
  input  logic              cpu_read,
  input  logic [DATA_W-1:0] cpu_wq,
  output logic [DATA_W-1:0] cpu_rq,
  output logic              cpu_wrq,
  output logic              cpu_rwq,
  output logic              cpu_done,
  input  logic              eng_req,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [6:0]        eng_len,
  input  logic              eng_write,
  input  logic [DATA_W-1:0] eng_wdata,
  input  logic              eng_wvalid,
  output logic              eng_wnext,
  output logic [DATA_W-1:0] eng_rdata,
  output logic              eng_rvalid,
  output logic              eng_busy,
  output logic              eng_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
`ifdef COPIER_DM_PERF_EN
  ,
  output logic [15:0]       perf_cpu_wait,
  output logic [15:0]       perf_eng_words
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CPU  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [6:0] MAX_LEN = 7'd64;
  localparam int         RUN_W   = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_BURST - 1);

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [6:0]        cnt;
  logic [6:0]        len;
  logic              dir;
  logic              active;
  logic              guard;
  logic [RUN_W-1:0]  run_cnt;

  logic              cpu_pend;
  logic              accept;
  logic              eng_word;
  logic              last_word;
  logic              run_hit;
  logic [6:0]        len_clamped;
  logic [ADDR_W-1:0] eng_ram_a;

  // guard blocks a re-grant in the cycle after cpu_done while the AQ advances
  assign cpu_pend    = cpu_sel & ~guard;
  assign accept      = (state == S_IDLE) & ~cpu_pend & eng_req;
  assign len_clamped = (eng_len > MAX_LEN) ? MAX_LEN : eng_len;
  assign eng_word    = (state == S_RUN) & (~dir | eng_wvalid);
  assign last_word   = eng_word & (cnt == len - 7'd1);
  assign run_hit     = eng_word & cpu_sel & (run_cnt == RUN_LAST);
  assign eng_ram_a   = base + ADDR_W'(cnt);
  assign eng_busy    = active;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_nxt = state;
    cpu_rq    = '0;
    cpu_wrq   = 1'b0;
    cpu_rwq   = 1'b0;
    cpu_done  = 1'b0;
    eng_wnext = 1'b0;
    eng_done  = 1'b0;
    ram_a     = '0;
    ram_d     = '0;
    ram_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cpu_pend)     state_nxt = S_CPU;
        else if (eng_req) state_nxt = (eng_len == 7'd0) ? S_FIN : S_RUN;
      end
      S_CPU: begin
        ram_a     = cpu_aq;
        ram_d     = cpu_wq;
        ram_we    = ~cpu_read;
        cpu_done  = 1'b1;
        cpu_rq    = ram_q;
        cpu_wrq   = cpu_read;
        cpu_rwq   = ~cpu_read;
        state_nxt = active ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        ram_a = eng_ram_a;
        if (dir && eng_wvalid) begin
          ram_we    = 1'b1;
          ram_d     = eng_wdata;
          eng_wnext = 1'b1;
        end
        // the last word always wins over a preemption due in the same cycle
        if (last_word)
          state_nxt = S_FIN;
        else if (cpu_pend && (run_hit || (dir && !eng_wvalid)))
          state_nxt = S_CPU;
      end
      S_FIN: begin
        eng_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      base       <= '0;
      cnt        <= '0;
      len        <= '0;
      dir        <= 1'b0;
      active     <= 1'b0;
      guard      <= 1'b0;
      run_cnt    <= '0;
      eng_rdata  <= '0;
      eng_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      guard      <= (state == S_CPU);
      eng_rvalid <= eng_word & ~dir;
      if (eng_word && !dir) eng_rdata <= ram_q;

      if (accept) begin
        base   <= eng_addr;
        cnt    <= '0;
        len    <= len_clamped;
        dir    <= eng_write;
        active <= 1'b1;
      end else begin
        if (eng_word)         cnt    <= cnt + 7'd1;
        if (state == S_FIN)   active <= 1'b0;
      end

      if (state_nxt == S_CPU || !cpu_sel)
        run_cnt <= '0;
      else if (eng_word && run_cnt != RUN_LAST)
        run_cnt <= run_cnt + 1'b1;
    end
  end

`ifdef COPIER_DM_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_cpu_wait  <= '0;
      perf_eng_words <= '0;
    end else begin
      if (cpu_sel && !cpu_done && perf_cpu_wait != 16'hFFFF)
        perf_cpu_wait <= perf_cpu_wait + 16'd1;
      if (eng_word && perf_eng_words != 16'hFFFF)
        perf_eng_words <= perf_eng_words + 16'd1;
    end
  end
`endif

endmodule
